// File: rtl/pc_stack.sv
// Program counter with hardware call/return stack, driving a shared tri-state address bus.
// Optional relative branch (pc_br) enabled by defining PC_REL_BRANCH_EN.
module pc_stack #(
  parameter int AW    = 4,
  parameter int DEPTH = 4,
  parameter int SPW   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pc_en,
  input  logic           pc_jmp,
  input  logic           pc_call,
  input  logic           pc_ret,
  input  logic           pc_br,
  input  logic           pc_out,
  input  logic           err_clr,
  inout  wire  [AW-1:0]  pc_bus,
  output logic [AW-1:0]  pc_value,
  output logic [SPW-1:0] sp,
  output logic           stk_full,
  output logic           stk_empty,
  output logic           stk_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [AW-1:0]  pc_data;
  logic [AW-1:0]  pc_inc;
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] sp_dec;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  top_idx;
  logic           push;
  logic           err_set;
  logic [AW-1:0]  stack_mem [2**IW];

  assign pc_bus    = pc_out ? pc_data : {AW{1'bz}};
  assign pc_value  = pc_data;
  assign sp        = sp_q;
  assign stk_full  = (sp_q == SP_FULL);
  assign stk_empty = (sp_q == '0);

  assign pc_inc  = pc_data + 1'b1;
  assign sp_dec  = sp_q - 1'b1;
  assign wr_idx  = sp_q[IW-1:0];
  assign top_idx = sp_dec[IW-1:0];

  // ret outranks call, so a simultaneous call never pushes or flags overflow
  assign push    = !pc_ret && pc_call && !stk_full;
  assign err_set = (pc_ret && stk_empty) || (!pc_ret && pc_call && stk_full);

`ifndef PC_REL_BRANCH_EN
  logic unused_br;
  assign unused_br = pc_br;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_data <= '0;
      sp_q    <= '0;
      stk_err <= 1'b0;
    end else begin
      if (pc_ret) begin
        if (!stk_empty) begin
          pc_data <= stack_mem[top_idx];
          sp_q    <= sp_dec;
        end
      end else if (pc_call) begin
        if (!stk_full) begin
          pc_data <= pc_bus;
          sp_q    <= sp_q + 1'b1;
        end
      end else if (pc_jmp) begin
        pc_data <= pc_bus;
`ifdef PC_REL_BRANCH_EN
      end else if (pc_br) begin
        // modular AW-bit add is the two's-complement signed offset
        pc_data <= pc_data + pc_bus;
`endif
      end else if (pc_en) begin
        pc_data <= pc_inc;
      end

      if (err_set)
        stk_err <= 1'b1;
      else if (err_clr)
        stk_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      stack_mem[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack (AW=4, DEPTH=4).
module tb_pc_stack;

  logic       clk = 1'b0;
  logic       rst, pc_en, pc_jmp, pc_call, pc_ret, pc_br, pc_out, err_clr;
  logic       bus_en;
  logic [3:0] bus_drv;
  wire  [3:0] pc_bus;
  logic [3:0] pc_value;
  logic [2:0] sp;
  logic       stk_full, stk_empty, stk_err;
  int         checks = 0;
  int         errors = 0;

  assign pc_bus = bus_en ? bus_drv : 4'bzzzz;

  pc_stack #(.AW(4), .DEPTH(4), .SPW(3)) dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .pc_jmp(pc_jmp), .pc_call(pc_call),
    .pc_ret(pc_ret), .pc_br(pc_br), .pc_out(pc_out), .err_clr(err_clr),
    .pc_bus(pc_bus), .pc_value(pc_value), .sp(sp), .stk_full(stk_full),
    .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; pc_en = 0; pc_jmp = 0; pc_call = 0; pc_ret = 0; pc_br = 0;
    pc_out = 0; err_clr = 0; bus_en = 0; bus_drv = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drive_bus(input logic [3:0] v);
    bus_en = 1; bus_drv = v;
  endtask

  initial begin
    idle();
    #2;
    // reset, then free-running increment with wrap
    rst = 1; pc_call = 1; pc_en = 1;
    tick();
    chk("rst_pc", 8'(pc_value), 8'h0);
    chk("rst_sp", 8'(sp), 8'h0);
    chk("rst_empty", 8'(stk_empty), 8'h1);
    chk("rst_full", 8'(stk_full), 8'h0);
    chk("rst_err", 8'(stk_err), 8'h0);
    for (int i = 1; i <= 17; i++) begin
      pc_en = 1;
      tick();
      chk($sformatf("inc_%0d", i), 8'(pc_value), 8'(i % 16));
    end
    chk("inc_sp", 8'(sp), 8'h0);
    drive_bus(4'h5);
    #1;
    chk("bus_released", 8'(pc_bus), 8'h5);

    // single call / return
    drive_bus(4'h5); pc_jmp = 1; tick();
    chk("jmp5", 8'(pc_value), 8'h5);
    drive_bus(4'hA); pc_call = 1; tick();
    chk("call_pc", 8'(pc_value), 8'hA);
    chk("call_sp", 8'(sp), 8'h1);
    pc_ret = 1; tick();
    chk("ret_pc", 8'(pc_value), 8'h6);
    chk("ret_sp", 8'(sp), 8'h0);
    chk("ret_empty", 8'(stk_empty), 8'h1);

    // nested calls to full, overflow, clear, unwind
    drive_bus(4'h1); pc_jmp = 1; tick();
    drive_bus(4'h3); pc_call = 1; tick();
    drive_bus(4'h7); pc_call = 1; tick();
    drive_bus(4'h9); pc_call = 1; tick();
    drive_bus(4'hB); pc_call = 1; tick();
    chk("nest_pc", 8'(pc_value), 8'hB);
    chk("nest_sp", 8'(sp), 8'h4);
    chk("nest_full", 8'(stk_full), 8'h1);
    chk("nest_err0", 8'(stk_err), 8'h0);
    drive_bus(4'hE); pc_call = 1; tick();
    chk("ovf_pc", 8'(pc_value), 8'hB);
    chk("ovf_sp", 8'(sp), 8'h4);
    chk("ovf_err", 8'(stk_err), 8'h1);
    err_clr = 1; tick();
    chk("clr_err", 8'(stk_err), 8'h0);
    pc_ret = 1; tick();
    chk("unw1", 8'(pc_value), 8'hA);
    pc_ret = 1; tick();
    chk("unw2", 8'(pc_value), 8'h8);
    pc_ret = 1; tick();
    chk("unw3", 8'(pc_value), 8'h4);
    pc_ret = 1; tick();
    chk("unw4", 8'(pc_value), 8'h2);
    chk("unw_sp", 8'(sp), 8'h0);

    // underflow, set beats clear, ret beats call
    pc_ret = 1; tick();
    chk("udf_pc", 8'(pc_value), 8'h2);
    chk("udf_err", 8'(stk_err), 8'h1);
    pc_ret = 1; err_clr = 1; tick();
    chk("set_beats_clr", 8'(stk_err), 8'h1);
    err_clr = 1; tick();
    chk("clr2", 8'(stk_err), 8'h0);
    drive_bus(4'h5); pc_call = 1; tick();
    chk("call5_sp", 8'(sp), 8'h1);
    drive_bus(4'hC); pc_ret = 1; pc_call = 1; tick();
    chk("retcall_pc", 8'(pc_value), 8'h3);
    chk("retcall_sp", 8'(sp), 8'h0);
    chk("retcall_err", 8'(stk_err), 8'h0);

    // call beats jmp (distinguished by sp)
    drive_bus(4'hD); pc_call = 1; pc_jmp = 1; tick();
    chk("calljmp_pc", 8'(pc_value), 8'hD);
    chk("calljmp_sp", 8'(sp), 8'h1);
    pc_ret = 1; tick();
    chk("calljmp_ret", 8'(pc_value), 8'h4);

    // bus drive and self-reload
    pc_out = 1;
    #1;
    chk("bus_drive", 8'(pc_bus), 8'h4);
    pc_out = 1; pc_jmp = 1; tick();
    chk("self_jmp", 8'(pc_value), 8'h4);
    drive_bus(4'h9); pc_jmp = 1; pc_en = 1; tick();
    chk("jmp_over_en", 8'(pc_value), 8'h9);

    // reset mid-call discards the push
    drive_bus(4'h7); pc_call = 1; rst = 1; tick();
    chk("rstcall_pc", 8'(pc_value), 8'h0);
    chk("rstcall_sp", 8'(sp), 8'h0);

    // relative branch
    drive_bus(4'h3); pc_jmp = 1; tick();
    drive_bus(4'hE); pc_br = 1; tick();
`ifdef PC_REL_BRANCH_EN
    chk("br_neg", 8'(pc_value), 8'h1);
    drive_bus(4'hF); pc_jmp = 1; tick();
    drive_bus(4'h2); pc_br = 1; tick();
    chk("br_wrap", 8'(pc_value), 8'h1);
    drive_bus(4'h6); pc_br = 1; pc_jmp = 1; tick();
    chk("jmp_over_br", 8'(pc_value), 8'h6);
    drive_bus(4'h2); pc_br = 1; pc_en = 1; tick();
    chk("br_over_en", 8'(pc_value), 8'h8);
`else
    chk("br_ignored", 8'(pc_value), 8'h3);
    drive_bus(4'hE); pc_br = 1; pc_en = 1; tick();
    chk("br_fallthru", 8'(pc_value), 8'h4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
